priority_arbiter: RTL and testbench
===================================

// Module: priority_arbiter
// PURPOSE
//   Registered, parametrised successor to the combinational priority encoder. Collects
//   N request lines (sticky or level) and selects one winner per grant. Winner chosen
//   by fixed priority (highest index wins) or round-robin. Result offered over a
//   valid/ready handshake. Sits between peripheral/interrupt sources and the XIO
//   sequencer that services them.
// PARAMETERS
//   NUM_REQ   8   number of request channels, 2..32
//   RR_MODE   0   0 = fixed priority (highest index wins), 1 = round-robin
//   STICKY    1   1 = requests latched until granted; 0 = level (pending == req_i & mask_i)
// PORTS
//   clk        in   1            system clock, single clock domain
//   rst        in   1            asynchronous, active-high reset
//   req_i      in   NUM_REQ      request lines, one per channel
//   mask_i     in   NUM_REQ      1 = channel enabled for arbitration
//   ready_i    in   1            consumer accepts current grant
//   valid_o    out  1            grant offer valid
//   index_o    out  IDX_W+1      winner index; MSB set = no winner (IDX_W = $clog2(NUM_REQ))
//   grant_o    out  NUM_REQ      one-hot winner, all-zero when !valid_o
//   pending_o  out  NUM_REQ      current pending register (STICKY=1) or req_i&mask_i
// BEHAVIOUR
//   Reset (async, rst=1): pending=0, rr_ptr=0, valid_o=0, grant_o=0,
//     index_o = {1'b1, IDX_W'0} (8'h... e.g. 4'h8 for NUM_REQ=8), state=IDLE.
//   Pending (STICKY=1): pending_next = (pending & ~clr) | req_i; clr = grant_o when
//     valid_o&&ready_i. Set wins over clear for the same bit in the same cycle.
//   Eligible = pending & mask_i. Masked bits stay pending, never win.
//   Winner select: fixed = highest set eligible index. RR = first eligible index at or
//     above rr_ptr scanning upward, wrapping NUM_REQ-1 -> 0; ties resolved by that order.
//   FSM states IDLE, OFFER:
//     IDLE: eligible!=0 at edge t -> valid_o=1, index_o/grant_o registered at t+1; -> OFFER.
//     OFFER: index_o/grant_o/valid_o held stable while !ready_i, even if the request
//       drops or the channel is masked (no withdrawal).
//     OFFER & ready_i: accept. rr_ptr <= (winner+1) mod NUM_REQ (wraps to 0). Re-arbitrate
//       same cycle on eligible with accepted bit excluded (and this cycle's new req_i):
//       non-zero -> stay OFFER with new winner next cycle (back-to-back, 1 grant/cycle);
//       zero -> IDLE, valid_o=0, index_o=no-winner.
//   Latency: request to valid_o = 1 cycle. index MSB set iff valid_o=0.
//   STICKY=0: an accepted channel whose req_i stays high may be granted again next cycle.
//   rst asserted mid-OFFER: offer dropped immediately, pending lost; no grant replayed.
//   rr_ptr only advances on accept; unused in fixed mode.
// STRUCTURE
//   Shared package xio_arb_pkg: arb_state_t enum {IDLE, OFFER}; function
//     idx_none(IDX_W) returning the no-winner code.
//   Sub-module priority_encoder_n (combinational, NUM_REQ-wide, MSB-none index):
//     used twice for RR (masked-upper and full vector), once for fixed mode.
//   Top holds pending reg, rr_ptr, FSM, output regs.
// TESTING
//   Reset: rst=1 mid-OFFER -> valid_o=0, index_o=4'h8, grant_o=0, pending_o=0 same cycle.
//   Fixed, NUM_REQ=8: req_i=8'b0010_0101 one cycle, ready_i=1 -> grants 5,2,0 on 3
//     consecutive cycles, then index_o=4'h8.
//   RR: req_i=8'hFF held, ready_i=1 -> indices 0,1,...,7,0 (wrap), one per cycle.
//   Backpressure: req 3, ready_i=0 for 4 cycles, req 3 dropped -> index_o=3 stable,
//     grant_o=8'h08; accept on 5th cycle clears pending bit 3.
//   Mask: req_i=8'h81, mask_i=8'h01 -> grant 0; pending_o keeps bit 7; unmask -> grant 7.
//   Set/clear collision: accept of ch 4 with req_i[4]=1 same cycle -> pending_o[4]=1, regranted.

Source files
------------

// File: rtl/xio_arb_pkg.sv
// Shared arbitration types and helpers for the XIO request arbiter.
//   arb_state_t : arbiter FSM state (IDLE, OFFER)
//   idx_none()  : no-winner index code (only the MSB set) for a given index width
package xio_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    // No-winner code: bit idx_w set, lower idx_w bits clear. Callers cast to IDX_W+1 bits.
    function automatic logic [31:0] idx_none(input int unsigned idx_w);
        return 32'(1) << idx_w;
    endfunction

endpackage

// File: rtl/priority_encoder_n.sv
// Combinational N-wide priority encoder with a "no winner" flag in the index MSB.
//   vec_i : request vector to encode
//   idx_o : {none, index}; none=1 when vec_i is all zero
// LSB_FIRST=1 picks the lowest set bit, LSB_FIRST=0 picks the highest set bit.
module priority_encoder_n
    import xio_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0,
    localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W:0]   idx_o
);

    localparam logic [IDX_W:0] IDX_NONE = (IDX_W + 1)'(idx_none(IDX_W));

    // The last match in scan order wins, so scan direction sets the priority.
    always_comb begin
        idx_o = IDX_NONE;
        if (LSB_FIRST) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (vec_i[i]) idx_o = {1'b0, IDX_W'(i)};
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (vec_i[i]) idx_o = {1'b0, IDX_W'(i)};
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// Registered N-channel request arbiter with valid/ready grant offer.
//   clk, rst   : clock, asynchronous active-high reset
//   req_i      : request lines (latched when STICKY=1, level when STICKY=0)
//   mask_i     : per-channel enable; masked requests stay pending but never win
//   ready_i    : consumer accepts the current offer
//   valid_o    : grant offer valid
//   index_o    : winner index, MSB set = no winner
//   grant_o    : one-hot winner, zero when !valid_o
//   pending_o  : pending register (STICKY=1) or req_i & mask_i (STICKY=0)
module priority_arbiter
    import xio_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 8,
    parameter int unsigned  RR_MODE = 0,
    parameter int unsigned  STICKY  = 1,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [IDX_W:0]     index_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [NUM_REQ-1:0] pending_o
);

    localparam logic [IDX_W:0]   IDX_NONE = (IDX_W + 1)'(idx_none(IDX_W));
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t         state_q;
    logic               valid_q;
    logic [IDX_W:0]     idx_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] pend_q;
    logic [NUM_REQ-1:0] pend_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_d;

    logic               accept;
    logic [NUM_REQ-1:0] clr;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] upper_mask;
    logic [IDX_W:0]     fix_idx;
    logic [IDX_W:0]     rr_upper_idx;
    logic [IDX_W:0]     rr_full_idx;
    logic [IDX_W:0]     rr_idx;
    logic [IDX_W:0]     win_idx;
    logic               win_valid;
    logic [NUM_REQ-1:0] win_onehot;

    // Next pending set and the eligible vector used for this cycle's arbitration.
    // Arbitrating on the next pending value gives 1-cycle request-to-valid latency
    // and lets an accept re-arbitrate in the same cycle; a set beats a clear.
    always_comb begin
        accept = valid_q & ready_i;
        clr    = accept ? grant_q : '0;
        pend_d = (STICKY != 0) ? ((pend_q & ~clr) | req_i) : req_i;
        elig   = pend_d & mask_i;
    end

    // Round-robin pointer moves past the accepted winner; the re-arbitration in
    // the accept cycle already uses the advanced pointer.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (idx_q[IDX_W-1:0] == IDX_LAST) ? '0 : idx_q[IDX_W-1:0] + IDX_W'(1);
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            upper_mask[i] = (32'(rr_ptr_d) <= 32'(i));
        end
    end

    priority_encoder_n #(.WIDTH(NUM_REQ), .LSB_FIRST(1'b0)) u_enc_fix (
        .vec_i (elig),
        .idx_o (fix_idx)
    );

    priority_encoder_n #(.WIDTH(NUM_REQ), .LSB_FIRST(1'b1)) u_enc_rr_upper (
        .vec_i (elig & upper_mask),
        .idx_o (rr_upper_idx)
    );

    priority_encoder_n #(.WIDTH(NUM_REQ), .LSB_FIRST(1'b1)) u_enc_rr_full (
        .vec_i (elig),
        .idx_o (rr_full_idx)
    );

    // RR: first eligible at/above the pointer, else wrap to the lowest eligible.
    always_comb begin
        rr_idx    = rr_upper_idx[IDX_W] ? rr_full_idx : rr_upper_idx;
        win_idx   = (RR_MODE != 0) ? rr_idx : fix_idx;
        win_valid = ~win_idx[IDX_W];
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            win_onehot[i] = win_valid && (win_idx[IDX_W-1:0] == IDX_W'(i));
        end
    end

    // Arbiter FSM with registered offer outputs; the offer is frozen until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            idx_q    <= IDX_NONE;
            grant_q  <= '0;
            pend_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            pend_q   <= (STICKY != 0) ? pend_d : '0;
            rr_ptr_q <= rr_ptr_d;
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q <= OFFER;
                        valid_q <= 1'b1;
                        idx_q   <= win_idx;
                        grant_q <= win_onehot;
                    end
                end
                OFFER: begin
                    if (ready_i) begin
                        if (win_valid) begin
                            valid_q <= 1'b1;
                            idx_q   <= win_idx;
                            grant_q <= win_onehot;
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            idx_q   <= IDX_NONE;
                            grant_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    idx_q   <= IDX_NONE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign valid_o   = valid_q;
    assign index_o   = idx_q;
    assign grant_o   = grant_q;
    assign pending_o = (STICKY != 0) ? pend_q : (req_i & mask_i);

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: a fixed-priority and a round-robin instance share
// the same stimulus; both are checked every cycle against a behavioural model,
// plus directed checks of the documented scenarios.
module tb_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] mask = 8'hFF;
    logic       ready = 1'b0;

    logic       f_valid, r_valid;
    logic [3:0] f_idx, r_idx;
    logic [7:0] f_grant, r_grant, f_pend, r_pend;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    priority_arbiter #(.NUM_REQ(8), .RR_MODE(0), .STICKY(1)) u_fix (
        .clk(clk), .rst(rst), .req_i(req), .mask_i(mask), .ready_i(ready),
        .valid_o(f_valid), .index_o(f_idx), .grant_o(f_grant), .pending_o(f_pend)
    );

    priority_arbiter #(.NUM_REQ(8), .RR_MODE(1), .STICKY(1)) u_rr (
        .clk(clk), .rst(rst), .req_i(req), .mask_i(mask), .ready_i(ready),
        .valid_o(r_valid), .index_o(r_idx), .grant_o(r_grant), .pending_o(r_pend)
    );

    // Behavioural model: set of pending channels plus the current offer.
    typedef struct {
        logic [7:0] pend;
        bit         valid;
        int         idx;
        int         ptr;
    } mdl_t;

    mdl_t m_fix, m_rr;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.pend  = 8'h00;
        m.valid = 1'b0;
        m.idx   = -1;
        m.ptr   = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input logic [7:0] r,
                                      input logic [7:0] mk, input bit rdy, input bit rr);
        mdl_t n;
        bit   acc;
        int   j;
        n   = m;
        acc = m.valid && rdy;
        for (int i = 0; i < 8; i++)
            n.pend[i] = (m.pend[i] && !(acc && i == m.idx)) || r[i];
        if (acc) n.ptr = (m.idx + 1) % 8;
        if (!m.valid || acc) begin
            n.valid = 1'b0;
            n.idx   = -1;
            if (!rr) begin
                for (int i = 0; i < 8; i++)
                    if (n.pend[i] && mk[i]) begin n.valid = 1'b1; n.idx = i; end
            end else begin
                for (int k = 7; k >= 0; k--) begin
                    j = (n.ptr + k) % 8;
                    if (n.pend[j] && mk[j]) begin n.valid = 1'b1; n.idx = j; end
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string nm, input mdl_t m, input logic v,
                             input logic [3:0] idx, input logic [7:0] g, input logic [7:0] p);
        logic [7:0] eg;
        eg = m.valid ? (8'h01 << m.idx) : 8'h00;
        chk({nm, ".valid"},   32'(v),   32'(m.valid));
        chk({nm, ".index"},   32'(idx), m.valid ? 32'(m.idx) : 32'h8);
        chk({nm, ".grant"},   32'(g),   32'(eg));
        chk({nm, ".pending"}, 32'(p),   32'(m.pend));
    endtask

    // One clock: model advances on the inputs present at the edge, outputs checked after it.
    task automatic step();
        @(posedge clk);
        m_fix = mdl_next(m_fix, req, mask, ready, 1'b0);
        m_rr  = mdl_next(m_rr,  req, mask, ready, 1'b1);
        #1;
        chk_model("fix", m_fix, f_valid, f_idx, f_grant, f_pend);
        chk_model("rr",  m_rr,  r_valid, r_idx, r_grant, r_pend);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00; mask = 8'hFF; ready = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_fix = mdl_reset();
        m_rr  = mdl_reset();
        chk("reset.valid",   32'(f_valid), 32'h0);
        chk("reset.index",   32'(f_idx),   32'h8);
        chk("reset.grant",   32'(f_grant), 32'h0);
        chk("reset.pending", 32'(r_pend),  32'h0);
    endtask

    initial begin
        m_fix = mdl_reset();
        m_rr  = mdl_reset();

        // Fixed priority drains 5,2,0 back to back, then idles
        do_reset();
        ready = 1'b1; req = 8'b0010_0101;
        step(); chk("fixed.g5", 32'(f_idx), 32'd5);
        req = 8'h00;
        step(); chk("fixed.g2", 32'(f_idx), 32'd2);
        step(); chk("fixed.g0", 32'(f_idx), 32'd0);
        step(); chk("fixed.none", 32'(f_idx), 32'h8);
        chk("fixed.none_valid", 32'(f_valid), 32'h0);

        // Round-robin walks 0..7 and wraps to 0 with all requests held
        do_reset();
        ready = 1'b1; req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("rr.seq%0d", i), 32'(r_idx), 32'(i % 8));
        end

        // Backpressure holds the offer stable after the request drops
        do_reset();
        ready = 1'b0; req = 8'h08;
        step();
        req = 8'h00;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp.idx%0d", i),   32'(f_idx),   32'd3);
            chk($sformatf("bp.grant%0d", i), 32'(f_grant), 32'h08);
            if (i < 3) step();
        end
        ready = 1'b1;
        step();
        chk("bp.cleared", 32'(f_pend[3]), 32'h0);
        chk("bp.idle",    32'(f_valid),   32'h0);

        // Masked channel stays pending and wins once unmasked
        do_reset();
        ready = 1'b0; req = 8'h81; mask = 8'h01;
        step();
        chk("mask.g0",   32'(f_idx),  32'd0);
        chk("mask.pend", 32'(f_pend), 32'h81);
        req = 8'h00; ready = 1'b1;
        step();
        chk("mask.keep7", 32'(f_pend), 32'h80);
        chk("mask.idle",  32'(f_valid), 32'h0);
        mask = 8'hFF;
        step();
        chk("mask.g7", 32'(f_idx), 32'd7);

        // Set wins over clear: accepted channel re-requesting is granted again
        do_reset();
        ready = 1'b0; req = 8'h10;
        step();
        chk("coll.g4", 32'(f_idx), 32'd4);
        ready = 1'b1;
        step();
        chk("coll.pend4", 32'(f_pend[4]), 32'h1);
        chk("coll.regrant", 32'(f_idx), 32'd4);
        chk("coll.rr_regrant", 32'(r_idx), 32'd4);

        // Asynchronous reset in the middle of an offer
        do_reset();
        ready = 1'b0; req = 8'h02;
        step();
        chk("rst.pre_valid", 32'(f_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst.async_valid", 32'(f_valid), 32'h0);
        chk("rst.async_index", 32'(f_idx),   32'h8);
        chk("rst.async_grant", 32'(r_grant), 32'h0);
        chk("rst.async_pend",  32'(f_pend),  32'h0);
        do_reset();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            req   = 8'($urandom) & 8'($urandom) & 8'($urandom);
            mask  = 8'($urandom) | 8'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
